// File: rtl/stream_fifo_pkg.sv
// rtl/stream_fifo_pkg.sv - shared constants, types and width helpers for the stream FIFO
package stream_fifo_pkg;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_DEPTH       = 4;
    localparam int DEFAULT_COUNT_WIDTH = $clog2(DEFAULT_DEPTH + 1);

    // Occupancy type for a FIFO built with the default depth.
    typedef logic [DEFAULT_COUNT_WIDTH-1:0] count_t;

    // Pointer width; never narrower than one bit.
    function automatic int calc_ptr_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // Occupancy width: must represent 0..depth inclusive.
    function automatic int calc_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_fifo_ptr_ctrl.sv
// rtl/stream_fifo_ptr_ctrl.sv - pointers, occupancy, flush and overflow tracking for the stream FIFO
module stream_fifo_ptr_ctrl
    import stream_fifo_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = calc_ptr_width(DEPTH),
    localparam int CW    = calc_count_width(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_push_valid,
    input  logic          i_pop_ready,
    output logic          o_push_ready,
    output logic          o_pop_valid,
    output logic          o_push_en,
    output logic          o_pop_en,
    output logic [PW-1:0] o_wr_ptr,
    output logic [PW-1:0] o_rd_ptr,
    output logic [CW-1:0] o_count,
    output logic          o_overflow
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    // Handshake qualifiers come from registered count only, so ready has no path from pop.
    always_comb begin
        o_push_ready = (count != FULL_COUNT);
        o_pop_valid  = (count != '0);
        o_push_en    = i_push_valid & o_push_ready;
        o_pop_en     = o_pop_valid & i_pop_ready;
    end

    // Pointer/count/overflow state; clear overrides any handshake in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (i_clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (o_push_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (o_pop_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (o_push_en && !o_pop_en) begin
                count <= count + CW'(1);
            end else if (o_pop_en && !o_push_en) begin
                count <= count - CW'(1);
            end
            if (i_push_valid && (count == FULL_COUNT)) begin
                overflow <= 1'b1;
            end
        end
    end

    assign o_wr_ptr   = wr_ptr;
    assign o_rd_ptr   = rd_ptr;
    assign o_count    = count;
    assign o_overflow = overflow;

endmodule

// File: rtl/stream_fifo_generic.sv
// rtl/stream_fifo_generic.sv - parametrised valid/ready stream FIFO with count, almost-full and overflow
module stream_fifo_generic
    import stream_fifo_pkg::*;
#(
    parameter  int WIDTH        = 8,
    parameter  int DEPTH        = 4,
    parameter  int AF_THRESHOLD = DEPTH - 1,
    localparam int CW           = calc_count_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_push_valid,
    output logic             o_push_ready,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_pop_valid,
    input  logic             i_pop_ready,
    output logic [WIDTH-1:0] o_pop_data,
    output logic [CW-1:0]    o_count,
    output logic             o_almost_full,
    output logic             o_overflow
);

    localparam int            PW      = calc_ptr_width(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL = CW'(AF_THRESHOLD);

    if (DEPTH < 2) begin : g_bad_depth
        $error("stream_fifo_generic: DEPTH must be at least 2");
    end
    if (AF_THRESHOLD < 1 || AF_THRESHOLD > DEPTH) begin : g_bad_af
        $error("stream_fifo_generic: AF_THRESHOLD must lie in 1..DEPTH");
    end

    logic             push_en;
    logic             pop_en;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    stream_fifo_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (i_clear),
        .i_push_valid (i_push_valid),
        .i_pop_ready  (i_pop_ready),
        .o_push_ready (o_push_ready),
        .o_pop_valid  (o_pop_valid),
        .o_push_en    (push_en),
        .o_pop_en     (pop_en),
        .o_wr_ptr     (wr_ptr),
        .o_rd_ptr     (rd_ptr),
        .o_count      (o_count),
        .o_overflow   (o_overflow)
    );

    // Storage is written only on an accepted push; contents survive reset and flush.
    always_ff @(posedge i_clk) begin
        if (push_en) begin
            mem[wr_ptr] <= i_push_data;
        end
    end

    // Head entry read straight out of the array so a pushed word is visible next cycle.
    always_comb begin
        o_pop_data    = mem[rd_ptr];
        o_almost_full = (o_count >= AF_LEVEL);
    end

endmodule
